// File: rtl/algo_2rw_a50_refr_ctl_pkg.sv
// Shared types and helpers for the 2rw algo refresh controller.
package algo_2rw_a50_refr_ctl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUE  = 2'd2
    } refr_state_e;

    // With the half-cycle fraction enabled, odd periods are one cycle longer.
    function automatic int unsigned period_sel(
        input int unsigned freq,
        input bit          halfCycle,
        input bit          phase
    );
        return freq + ((halfCycle && phase) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/algo_2rw_a50_refr_ctl_sat_cnt.sv
// Saturating up-counter used to tally issued refreshes.
module algo_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/algo_2rw_a50_refr_ctl.sv
// Refresh pulse generator for the 2rw algo core: periodic refresh with
// bounded host postponement, forced issue and saturating issue count.
module algo_2rw_a50_refr_ctl
    import algo_2rw_a50_refr_ctl_pkg::*;
#(
    parameter int REFRESH = 1,
    parameter int REFFREQ = 6,
    parameter int REFFRHF = 0,
    parameter int MAXPOST = 2,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ready,
    input  logic            ena,
    input  logic            hold,
    output logic            refr,
    output logic            refr_due,
    output logic            refr_force,
    output logic [CNTW-1:0] refr_cnt,
    output logic            refr_late
);

    localparam int  CW     = $clog2(REFFREQ + 2);
    localparam int  PW     = $clog2(MAXPOST + 2);
    localparam bit  NOPOST = (MAXPOST == 0);

    if (REFFREQ < 4) begin : g_chkFreq
        $error("algo_2rw_a50_refr_ctl: REFFREQ must be at least 4");
    end
    if (MAXPOST >= REFFREQ - 1) begin : g_chkPost
        $error("algo_2rw_a50_refr_ctl: MAXPOST must be below REFFREQ-1");
    end

    refr_state_e   r_state;
    refr_state_e   w_next;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_pc;
    logic          r_phase;
    logic          r_refr;
    logic          r_force;
    logic          r_late;

    logic [CW-1:0] w_periodM1;
    logic          w_active;
    logic          w_due;
    logic          w_pcLast;
    logic          w_issue;
    logic          w_forceIssue;

    assign w_periodM1 = CW'(period_sel(int'(REFFREQ), REFFRHF != 0, r_phase) - 32'd1);
    assign w_active   = ready & ena & (REFRESH != 0);
    assign w_due      = (r_state != ST_WAIT) && (r_cnt == w_periodM1);
    assign w_pcLast   = (int'(r_pc) + 1) >= MAXPOST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_WAIT: begin
                if (w_active) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!w_active)                      w_next = ST_WAIT;
                else if (w_due && hold && !NOPOST)  w_next = ST_DUE;
            end
            ST_DUE: begin
                if (!w_active)             w_next = ST_WAIT;
                else if (!hold || w_pcLast) w_next = ST_RUN;
            end
            default: w_next = ST_WAIT;
        endcase
    end

    // A refresh is only scheduled while the core stays enabled, so a drop
    // of ready/ena in the deciding cycle swallows the pulse.
    always_comb begin
        w_issue      = 1'b0;
        w_forceIssue = 1'b0;
        if (w_active) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_due && (!hold || NOPOST)) begin
                        w_issue      = 1'b1;
                        w_forceIssue = hold;
                    end
                end
                ST_DUE: begin
                    if (!hold || w_pcLast) begin
                        w_issue      = 1'b1;
                        w_forceIssue = hold;
                    end
                end
                default: ;
            endcase
        end
    end

    assign refr_due = (r_state == ST_DUE);

    // The period counter keeps running through postponement, so the next
    // due point stays anchored to the nominal schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pc    <= '0;
            r_phase <= 1'b0;
            r_refr  <= 1'b0;
            r_force <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            r_refr  <= w_issue;
            r_force <= w_forceIssue;
            r_late  <= r_late | w_forceIssue;
            if (!w_active) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                r_cnt   <= CW'(1);
                r_phase <= 1'b0;
            end else if (w_due) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
            r_pc <= ((r_state == ST_DUE) && (w_next == ST_DUE)) ? r_pc + PW'(1) : '0;
        end
    end

    algo_sat_cnt #(
        .W(CNTW)
    ) u_satCnt (
        .clk(clk),
        .rst(rst),
        .inc(r_refr),
        .cnt(refr_cnt)
    );

    assign refr       = r_refr;
    assign refr_force = r_force;
    assign refr_late  = r_late;

endmodule

// File: tb/tb_algo_2rw_a50_refr_ctl.sv
// Bench for the refresh controller: three parameterisations driven in lockstep,
// directed scenarios plus a randomized run against a schedule-level model.
module tb_algo_2rw_a50_refr_ctl;

    logic clk;
    logic rst;
    logic ready;
    logic ena;
    logic hold;

    logic        aRefr, aDue, aForce, aLate;
    logic [3:0]  aCnt;
    logic        bRefr, bDue, bForce, bLate;
    logic [15:0] bCnt;
    logic        cRefr, cDue, cForce, cLate;
    logic [15:0] cCnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int absT  = 0;

    // Instance 0: default schedule with a narrow counter, 1: half-cycle mode, 2: refresh disabled.
    int pFreq [3] = '{6, 6, 6};
    bit pHf   [3] = '{1'b0, 1'b1, 1'b0};
    bit pEn   [3] = '{1'b1, 1'b1, 1'b0};
    int pMax  [3] = '{15, 65535, 65535};
    int pPost     = 2;

    bit mActive  [3] = '{3{1'b0}};
    int mNextDue [3] = '{3{0}};
    int mPIdx    [3] = '{3{0}};
    int mPend    [3] = '{3{-1}};
    bit mRefr    [3] = '{3{1'b0}};
    bit mForce   [3] = '{3{1'b0}};
    bit mDue     [3] = '{3{1'b0}};
    bit mLate    [3] = '{3{1'b0}};
    int mCnt     [3] = '{3{0}};

    logic        obsRefr  [3];
    logic        obsDue   [3];
    logic        obsForce [3];
    logic        obsLate  [3];
    logic [15:0] obsCnt   [3];

    algo_2rw_a50_refr_ctl #(.REFRESH(1), .REFFREQ(6), .REFFRHF(0), .MAXPOST(2), .CNTW(4)) dutA (
        .clk(clk), .rst(rst), .ready(ready), .ena(ena), .hold(hold),
        .refr(aRefr), .refr_due(aDue), .refr_force(aForce), .refr_cnt(aCnt), .refr_late(aLate)
    );

    algo_2rw_a50_refr_ctl #(.REFRESH(1), .REFFREQ(6), .REFFRHF(1), .MAXPOST(2), .CNTW(16)) dutB (
        .clk(clk), .rst(rst), .ready(ready), .ena(ena), .hold(hold),
        .refr(bRefr), .refr_due(bDue), .refr_force(bForce), .refr_cnt(bCnt), .refr_late(bLate)
    );

    algo_2rw_a50_refr_ctl #(.REFRESH(0), .REFFREQ(6), .REFFRHF(0), .MAXPOST(2), .CNTW(16)) dutC (
        .clk(clk), .rst(rst), .ready(ready), .ena(ena), .hold(hold),
        .refr(cRefr), .refr_due(cDue), .refr_force(cForce), .refr_cnt(cCnt), .refr_late(cLate)
    );

    always_comb begin
        obsRefr[0]  = aRefr;  obsRefr[1]  = bRefr;  obsRefr[2]  = cRefr;
        obsDue[0]   = aDue;   obsDue[1]   = bDue;   obsDue[2]   = cDue;
        obsForce[0] = aForce; obsForce[1] = bForce; obsForce[2] = cForce;
        obsLate[0]  = aLate;  obsLate[1]  = bLate;  obsLate[2]  = cLate;
        obsCnt[0]   = {12'd0, aCnt};
        obsCnt[1]   = bCnt;
        obsCnt[2]   = cCnt;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Schedule-level model: nominal due instants are absolute times, a due refresh
    // is pending until hold releases or it has waited MAXPOST cycles.
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            int nCnt;
            bit issue;
            bit frc;
            nCnt  = mCnt[i] + (mRefr[i] ? 1 : 0);
            if (nCnt > pMax[i]) nCnt = pMax[i];
            issue = 1'b0;
            frc   = 1'b0;
            if (rst) begin
                mActive[i] = 1'b0;
                mPend[i]   = -1;
                mLate[i]   = 1'b0;
                nCnt       = 0;
            end else if (!(ready && ena && pEn[i])) begin
                mActive[i] = 1'b0;
                mPend[i]   = -1;
            end else begin
                if (!mActive[i]) begin
                    mActive[i]  = 1'b1;
                    mPIdx[i]    = 0;
                    mNextDue[i] = absT + pFreq[i] - 1;
                end else if (absT == mNextDue[i]) begin
                    mPend[i]    = absT;
                    mPIdx[i]    = mPIdx[i] + 1;
                    mNextDue[i] = absT + pFreq[i] + ((pHf[i] && (mPIdx[i] % 2 == 1)) ? 1 : 0);
                end
                if (mPend[i] >= 0 && (!hold || (absT - mPend[i]) >= pPost)) begin
                    issue    = 1'b1;
                    frc      = hold;
                    mPend[i] = -1;
                end
            end
            mRefr[i]  = issue;
            mForce[i] = frc;
            mDue[i]   = (mPend[i] >= 0);
            mLate[i]  = mLate[i] | frc;
            mCnt[i]   = nCnt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        absT = absT + 1;
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic startRun();
        rst   = 1'b1;
        ready = 1'b1;
        ena   = 1'b1;
        hold  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            rst   = 1'b1;
            ready = 1'($urandom_range(0, 1));
            ena   = 1'($urandom_range(0, 1));
            hold  = 1'($urandom_range(0, 1));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obsRefr[i] !== 1'b0 || obsDue[i] !== 1'b0 || obsForce[i] !== 1'b0 ||
                obsLate[i] !== 1'b0 || obsCnt[i] !== 16'd0) begin
                bad++;
                $display("[TB] FAIL reset inst%0d: got refr=%b due=%b force=%b late=%b cnt=%0d, want all 0",
                         i, obsRefr[i], obsDue[i], obsForce[i], obsLate[i], obsCnt[i]);
            end
        end
    endtask

    task automatic test_periodic();
        bit wantA, wantB;
        startRun();
        for (int n = 0; n < 35; n++) begin
            wantA = (cyc > 0) && (cyc % 6 == 0);
            wantB = (cyc == 6) || (cyc == 13) || (cyc == 19) || (cyc == 26) || (cyc == 32);
            total++;
            if (aRefr !== wantA || aForce !== 1'b0 || aDue !== 1'b0) begin
                bad++;
                $display("[TB] FAIL periodic_a cyc=%0d: got refr=%b force=%b due=%b, want refr=%b force=0 due=0",
                         cyc, aRefr, aForce, aDue, wantA);
            end
            total++;
            if (bRefr !== wantB) begin
                bad++;
                $display("[TB] FAIL halfcycle_b cyc=%0d: got refr=%b, want %b", cyc, bRefr, wantB);
            end
            total++;
            if (cRefr !== 1'b0 || cDue !== 1'b0 || cForce !== 1'b0) begin
                bad++;
                $display("[TB] FAIL disabled_c cyc=%0d: got refr=%b due=%b force=%b, want 0",
                         cyc, cRefr, cDue, cForce);
            end
            if (cyc == 19) begin
                total++;
                if (aCnt !== 4'd3) begin
                    bad++;
                    $display("[TB] FAIL cnt_at_19: got %0d, want 3", aCnt);
                end
            end
            if (cyc == 34) begin
                total++;
                if (bCnt !== 16'd5) begin
                    bad++;
                    $display("[TB] FAIL halfcycle_cnt: got %0d, want 5", bCnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold_once();
        bit wantRefr, wantDue, wantB;
        startRun();
        for (int n = 0; n < 16; n++) begin
            hold     = (cyc == 5);
            wantRefr = (cyc == 7) || (cyc == 12);
            wantDue  = (cyc == 6);
            wantB    = (cyc == 7) || (cyc == 13);
            total++;
            if (aRefr !== wantRefr || aDue !== wantDue || aForce !== 1'b0 || aLate !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_once cyc=%0d: got refr=%b due=%b force=%b late=%b, want refr=%b due=%b force=0 late=0",
                         cyc, aRefr, aDue, aForce, aLate, wantRefr, wantDue);
            end
            total++;
            if (bRefr !== wantB) begin
                bad++;
                $display("[TB] FAIL hold_once_b cyc=%0d: got refr=%b, want %b", cyc, bRefr, wantB);
            end
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic test_hold_stuck();
        bit wantRefr, wantDue, wantLate;
        startRun();
        hold = 1'b1;
        for (int n = 0; n < 19; n++) begin
            wantRefr = (cyc >= 8) && (cyc % 6 == 2);
            wantDue  = (cyc >= 6) && ((cyc % 6 == 0) || (cyc % 6 == 1));
            wantLate = (cyc >= 8);
            total++;
            if (aRefr !== wantRefr || aForce !== wantRefr || aDue !== wantDue || aLate !== wantLate) begin
                bad++;
                $display("[TB] FAIL hold_stuck cyc=%0d: got refr=%b force=%b due=%b late=%b, want refr=%b force=%b due=%b late=%b",
                         cyc, aRefr, aForce, aDue, aLate, wantRefr, wantRefr, wantDue, wantLate);
            end
            if (n < 18) tick();
        end
        rst = 1'b1;
        tick();
        total++;
        if (aRefr !== 1'b0 || aDue !== 1'b0 || aForce !== 1'b0 || aLate !== 1'b0 || aCnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_in_due: got refr=%b due=%b force=%b late=%b cnt=%0d, want all 0",
                     aRefr, aDue, aForce, aLate, aCnt);
        end
        rst  = 1'b0;
        hold = 1'b0;
    endtask

    task automatic test_ready_drop();
        bit wantRefr;
        startRun();
        for (int n = 0; n < 23; n++) begin
            ready    = !((cyc >= 5) && (cyc < 10));
            wantRefr = (cyc == 16) || (cyc == 22);
            total++;
            if (aRefr !== wantRefr || aDue !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ready_drop cyc=%0d: got refr=%b due=%b, want refr=%b due=0",
                         cyc, aRefr, aDue, wantRefr);
            end
            tick();
        end
        ready = 1'b1;
    endtask

    task automatic test_saturation();
        startRun();
        for (int n = 0; n < 101; n++) begin
            if (cyc == 90 || cyc == 91 || cyc == 100) begin
                total++;
                if (aCnt !== ((cyc == 90) ? 4'd14 : 4'd15)) begin
                    bad++;
                    $display("[TB] FAIL saturate cyc=%0d: got %0d, want %0d",
                             cyc, aCnt, (cyc == 90) ? 14 : 15);
                end
            end
            if (cyc == 100) begin
                total++;
                if (bCnt !== 16'd15) begin
                    bad++;
                    $display("[TB] FAIL wide_cnt cyc=100: got %0d, want 15", bCnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int holdBias;
        holdBias = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            if (n % 40 == 0) holdBias = $urandom_range(0, 3);
            rst   = ($urandom_range(0, 299) == 0);
            ready = ($urandom_range(0, 24) != 0);
            ena   = ($urandom_range(0, 39) != 0);
            hold  = (holdBias == 3) ? 1'b1 : ($urandom_range(0, 3) < holdBias);
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obsRefr[i] !== mRefr[i] || obsDue[i] !== mDue[i] || obsForce[i] !== mForce[i] ||
                    obsLate[i] !== mLate[i] || obsCnt[i] !== 16'(mCnt[i])) begin
                    bad++;
                    $display("[TB] FAIL random inst%0d t=%0d: got refr=%b due=%b force=%b late=%b cnt=%0d, want refr=%b due=%b force=%b late=%b cnt=%0d",
                             i, absT, obsRefr[i], obsDue[i], obsForce[i], obsLate[i], obsCnt[i],
                             mRefr[i], mDue[i], mForce[i], mLate[i], mCnt[i]);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        ena   = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_hold_once();
        test_hold_stuck();
        test_ready_drop();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
